// File: rtl/decode_wb_param.sv
// Y86-64 decode/writeback stage: source/destination decode, operand
// forwarding, load-use detection, E pipeline register and a 2-write
// register file with a debug read port.
module decode_wb_param #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned NUM_REGS   = 15,
  parameter int unsigned RSP_ID     = 4,
  parameter int unsigned INIT_INDEX = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        D_stat,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [ADDR_W-1:0] D_rA,
  input  logic [ADDR_W-1:0] D_rB,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic              E_stall,
  input  logic              E_bubble,
  input  logic [ADDR_W-1:0] e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [ADDR_W-1:0] M_dstE,
  input  logic [ADDR_W-1:0] M_dstM,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic              W_en,
  input  logic [ADDR_W-1:0] W_dstE,
  input  logic [ADDR_W-1:0] W_dstM,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  output logic [ADDR_W-1:0] d_srcA,
  output logic [ADDR_W-1:0] d_srcB,
  output logic              load_use,
  output logic [3:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [ADDR_W-1:0] E_dstE,
  output logic [ADDR_W-1:0] E_dstM,
  output logic [ADDR_W-1:0] E_srcA,
  output logic [ADDR_W-1:0] E_srcB,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [3:0] {
    I_HALT  = 4'h0,
    I_NOP   = 4'h1,
    I_CMOV  = 4'h2,
    I_IRMOV = 4'h3,
    I_RMMOV = 4'h4,
    I_MRMOV = 4'h5,
    I_OPQ   = 4'h6,
    I_JXX   = 4'h7,
    I_CALL  = 4'h8,
    I_RET   = 4'h9,
    I_PUSH  = 4'hA,
    I_POP   = 4'hB
  } icode_e;

  localparam logic [ADDR_W-1:0] NONE = '1;
  localparam logic [ADDR_W-1:0] RSP  = ADDR_W'(RSP_ID);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] dst_e, dst_m;
  logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;

  // Source/destination ID decode from the instruction code.
  always_comb begin
    d_srcA = NONE;
    d_srcB = NONE;
    dst_e  = NONE;
    dst_m  = NONE;
    case (D_icode)
      I_CMOV:  begin d_srcA = D_rA; dst_e = D_rB; end
      I_IRMOV: dst_e = D_rB;
      I_RMMOV: begin d_srcA = D_rA; d_srcB = D_rB; end
      I_MRMOV: begin d_srcB = D_rB; dst_m = D_rA; end
      I_OPQ:   begin d_srcA = D_rA; d_srcB = D_rB; dst_e = D_rB; end
      I_CALL:  begin d_srcB = RSP; dst_e = RSP; end
      I_RET:   begin d_srcA = RSP; d_srcB = RSP; dst_e = RSP; end
      I_PUSH:  begin d_srcA = D_rA; d_srcB = RSP; dst_e = RSP; end
      I_POP:   begin d_srcA = RSP; d_srcB = RSP; dst_e = RSP; dst_m = D_rA; end
      default: ;
    endcase
  end

  // Register-file reads; IDs outside 0..NUM_REGS-1 (including NONE) read as 0.
  always_comb begin
    rf_a     = '0;
    rf_b     = '0;
    dbg_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (d_srcA == ADDR_W'(i))   rf_a     = regs[i];
      if (d_srcB == ADDR_W'(i))   rf_b     = regs[i];
      if (dbg_addr == ADDR_W'(i)) dbg_data = regs[i];
    end
  end

  // Operand selection: valP for jXX/call, else newest forwarded value, else register file.
  always_comb begin
    if (D_icode == I_JXX || D_icode == I_CALL) val_a = D_valP;
    else if (d_srcA == NONE)                   val_a = '0;
    else if (d_srcA == e_dstE)                 val_a = e_valE;
    else if (d_srcA == M_dstM)                 val_a = m_valM;
    else if (d_srcA == M_dstE)                 val_a = M_valE;
    else if (d_srcA == W_dstM)                 val_a = W_valM;
    else if (d_srcA == W_dstE)                 val_a = W_valE;
    else                                       val_a = rf_a;

    if (d_srcB == NONE)        val_b = '0;
    else if (d_srcB == e_dstE) val_b = e_valE;
    else if (d_srcB == M_dstM) val_b = m_valM;
    else if (d_srcB == M_dstE) val_b = M_valE;
    else if (d_srcB == W_dstM) val_b = W_valM;
    else if (d_srcB == W_dstE) val_b = W_valE;
    else                       val_b = rf_b;
  end

  // Load-use hazard: a load in execute targets a register decode is reading.
  always_comb begin
    load_use = (E_icode == I_MRMOV || E_icode == I_POP) && (E_dstM != NONE) &&
               (E_dstM == d_srcA || E_dstM == d_srcB);
  end

  // E pipeline register: reset/bubble > stall > load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || E_bubble) begin
      E_stat  <= 4'b1000;
      E_icode <= I_NOP;
      E_ifun  <= '0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= NONE;
      E_dstM  <= NONE;
      E_srcA  <= NONE;
      E_srcB  <= NONE;
    end else if (!E_stall) begin
      E_stat  <= D_stat;
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valC  <= D_valC;
      E_valA  <= val_a;
      E_valB  <= val_b;
      E_dstE  <= dst_e;
      E_dstM  <= dst_m;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

  // Writeback; the M port is assigned last so it wins when both IDs collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
    end else if (W_en) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (W_dstE == ADDR_W'(i)) regs[i] <= W_valE;
        if (W_dstM == ADDR_W'(i)) regs[i] <= W_valM;
      end
    end
  end

endmodule

// File: tb/tb_decode_wb_param.sv
// Self-checking bench for decode_wb_param: a default instance (15 registers)
// and an 8-register instance share all stimulus; a table-driven reference
// model predicts decode, forwarding, E register and register-file contents.
module tb_decode_wb_param;

  localparam logic [3:0] NONE = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic        E_stall, E_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM, dbg_addr;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic        W_en;

  logic [3:0]  d_srcA, d_srcB, E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic        load_use;
  logic [63:0] E_valC, E_valA, E_valB, dbg_data;

  logic [3:0]  d_srcA8, d_srcB8, E_stat8, E_icode8, E_ifun8, E_dstE8, E_dstM8, E_srcA8, E_srcB8;
  logic        load_use8;
  logic [63:0] E_valC8, E_valA8, E_valB8, dbg_data8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_wb_param dut (
    .clk(clk), .rst_n(rst_n), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
    .E_stall(E_stall), .E_bubble(E_bubble), .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_en(W_en), .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .load_use(load_use),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  decode_wb_param #(.NUM_REGS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
    .E_stall(E_stall), .E_bubble(E_bubble), .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_en(W_en), .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .d_srcA(d_srcA8), .d_srcB(d_srcB8), .load_use(load_use8),
    .E_stat(E_stat8), .E_icode(E_icode8), .E_ifun(E_ifun8),
    .E_valC(E_valC8), .E_valA(E_valA8), .E_valB(E_valB8),
    .E_dstE(E_dstE8), .E_dstM(E_dstM8), .E_srcA(E_srcA8), .E_srcB(E_srcB8),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data8)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  stat, icode, ifun, dstE, dstM, srcA, srcB;
    logic [63:0] valC, valA, valB, valA8, valB8;
  } e_t;

  e_t          exp_e;
  logic [63:0] rf15 [15];
  logic [63:0] rf8  [8];

  // Per-icode field selectors: 0 = NONE, 1 = rA, 2 = rB, 3 = %rsp
  int sa_tab [16] = '{0,0,1,0,1,0,1,0,0,3,1,3,0,0,0,0};
  int sb_tab [16] = '{0,0,0,0,2,2,2,0,3,3,3,3,0,0,0,0};
  int de_tab [16] = '{0,0,2,2,0,0,2,0,3,3,3,3,0,0,0,0};
  int dm_tab [16] = '{0,0,0,0,0,1,0,0,0,0,0,1,0,0,0,0};

  function automatic logic [3:0] pick(int sel);
    case (sel)
      1:       return D_rA;
      2:       return D_rB;
      3:       return 4'd4;
      default: return NONE;
    endcase
  endfunction

  function automatic e_t bubble();
    e_t b;
    b.stat = 4'b1000; b.icode = 4'h1; b.ifun = 4'h0;
    b.valC = 64'h0; b.valA = 64'h0; b.valB = 64'h0; b.valA8 = 64'h0; b.valB8 = 64'h0;
    b.dstE = NONE; b.dstM = NONE; b.srcA = NONE; b.srcB = NONE;
    return b;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 15; i++) rf15[i] = 64'(i);
    for (int i = 0; i < 8; i++)  rf8[i]  = 64'(i);
    exp_e = bubble();
  endfunction

  function automatic logic [63:0] rd(int n, logic [3:0] id);
    if (int'(id) >= n) return 64'h0;
    if (n == 15) return rf15[id];
    return rf8[id[2:0]];
  endfunction

  function automatic logic [63:0] fwd(int n, logic [3:0] id, bit is_a);
    logic [3:0]  ids [5];
    logic [63:0] vs  [5];
    if (is_a && (D_icode == 4'h7 || D_icode == 4'h8)) return D_valP;
    if (id == NONE) return 64'h0;
    ids = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vs  = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    foreach (ids[k]) if (ids[k] == id) return vs[k];
    return rd(n, id);
  endfunction

  function automatic void wb_model();
    if (!W_en) return;
    if (int'(W_dstE) < 15) rf15[W_dstE] = W_valE;
    if (int'(W_dstM) < 15) rf15[W_dstM] = W_valM;
    if (int'(W_dstE) < 8)  rf8[W_dstE[2:0]] = W_valE;
    if (int'(W_dstM) < 8)  rf8[W_dstM[2:0]] = W_valM;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, predict, check E after the edge.
  task automatic cycle();
    logic [3:0] sa, sb;
    logic       lu;
    e_t         nx;
    @(negedge clk); #1;
    sa = pick(sa_tab[D_icode]);
    sb = pick(sb_tab[D_icode]);
    lu = (exp_e.icode == 4'h5 || exp_e.icode == 4'hB) && exp_e.dstM != NONE &&
         (exp_e.dstM == sa || exp_e.dstM == sb);
    chk("d_srcA", 64'(d_srcA), 64'(sa));
    chk("d_srcB", 64'(d_srcB), 64'(sb));
    chk("load_use", 64'(load_use), 64'(lu));
    chk("dbg_data", dbg_data, rd(15, dbg_addr));
    chk("dbg_data8", dbg_data8, rd(8, dbg_addr));
    nx = exp_e;
    if (E_bubble) nx = bubble();
    else if (!E_stall) begin
      nx.stat = D_stat; nx.icode = D_icode; nx.ifun = D_ifun; nx.valC = D_valC;
      nx.srcA = sa; nx.srcB = sb;
      nx.dstE = pick(de_tab[D_icode]); nx.dstM = pick(dm_tab[D_icode]);
      nx.valA = fwd(15, sa, 1'b1); nx.valB = fwd(15, sb, 1'b0);
      nx.valA8 = fwd(8, sa, 1'b1); nx.valB8 = fwd(8, sb, 1'b0);
    end
    @(posedge clk);
    exp_e = nx;
    wb_model();
    #1;
    chk("E_stat", 64'(E_stat), 64'(exp_e.stat));
    chk("E_icode", 64'(E_icode), 64'(exp_e.icode));
    chk("E_ifun", 64'(E_ifun), 64'(exp_e.ifun));
    chk("E_valC", E_valC, exp_e.valC);
    chk("E_valA", E_valA, exp_e.valA);
    chk("E_valB", E_valB, exp_e.valB);
    chk("E_dstE", 64'(E_dstE), 64'(exp_e.dstE));
    chk("E_dstM", 64'(E_dstM), 64'(exp_e.dstM));
    chk("E_srcA", 64'(E_srcA), 64'(exp_e.srcA));
    chk("E_srcB", 64'(E_srcB), 64'(exp_e.srcB));
    chk("E_valA8", E_valA8, exp_e.valA8);
    chk("E_valB8", E_valB8, exp_e.valB8);
  endtask

  task automatic clear_fwd();
    e_dstE = NONE; M_dstE = NONE; M_dstM = NONE; W_dstE = NONE; W_dstM = NONE;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0; W_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] held_icode;
    logic [63:0] held_valc;

    rst_n = 1'b0;
    D_stat = 4'h1; D_icode = 4'h1; D_ifun = 4'h0; D_rA = NONE; D_rB = NONE;
    D_valC = '0; D_valP = '0; E_stall = 1'b0; E_bubble = 1'b0; dbg_addr = '0;
    clear_fwd();
    model_reset();

    // Reset state and initial register contents
    repeat (2) @(posedge clk);
    #1;
    chk("rst_E_icode", 64'(E_icode), 64'h1);
    chk("rst_E_dstE", 64'(E_dstE), 64'hF);
    chk("rst_E_stat", 64'(E_stat), 64'h8);
    for (int i = 0; i < 15; i++) begin
      dbg_addr = 4'(i);
      #1 chk("rst_reg", dbg_data, 64'(i));
    end
    @(negedge clk) rst_n = 1'b1;

    // OPq with forwarding from execute taking priority over memory
    D_icode = 4'h6; D_rA = 4'd2; D_rB = 4'd3; D_valC = 64'h55;
    e_dstE = 4'd2; e_valE = 64'hAA; M_dstM = 4'd2; m_valM = 64'hBB;
    cycle();
    chk("opq_valA", E_valA, 64'hAA);
    chk("opq_valB", E_valB, 64'h3);

    // Dual write to the same register: the M port wins; then W_en=0 writes nothing
    clear_fwd();
    W_en = 1'b1; W_dstE = 4'd4; W_valE = 64'h100; W_dstM = 4'd4; W_valM = 64'h200;
    dbg_addr = 4'd4;
    cycle();
    #1 chk("wb_collision", dbg_data, 64'h200);
    W_en = 1'b0; W_valM = 64'h300; W_valE = 64'h301;
    cycle();
    #1 chk("wb_disabled", dbg_data, 64'h200);
    clear_fwd();

    // Load-use detection against an mrmovq in execute
    D_icode = 4'h5; D_rA = 4'd5; D_rB = 4'd6;
    cycle();
    D_icode = 4'h6; D_rA = 4'd5; D_rB = 4'd6;
    #1 chk("load_use_hit", 64'(load_use), 64'h1);
    D_rA = 4'd6; D_rB = 4'd7;
    #1 chk("load_use_miss", 64'(load_use), 64'h0);
    cycle();

    // Stall holds E; bubble overrides stall
    held_icode = exp_e.icode; held_valc = exp_e.valC;
    E_stall = 1'b1; D_icode = 4'h3; D_rB = 4'd1; D_valC = 64'hCAFE;
    cycle();
    chk("stall_icode", 64'(E_icode), 64'(held_icode));
    chk("stall_valC", E_valC, held_valc);
    E_bubble = 1'b1;
    cycle();
    chk("bubble_icode", 64'(E_icode), 64'h1);
    E_stall = 1'b0; E_bubble = 1'b0;

    // Out-of-range register 9 on the 8-register instance
    W_en = 1'b1; W_dstE = 4'd9; W_valE = 64'h999;
    cycle();
    clear_fwd();
    dbg_addr = 4'd9;
    #1 chk("oor_read8", dbg_data8, 64'h0);
    chk("inrange_read15", dbg_data, 64'h999);
    D_icode = 4'h6; D_rA = 4'd9; D_rB = 4'd2;
    cycle();
    chk("oor_valA8", E_valA8, 64'h0);

    // jXX passes valP through valA
    D_icode = 4'h7; D_valP = 64'h1234; D_rA = NONE; D_rB = NONE;
    cycle();
    chk("jxx_valA", E_valA, 64'h1234);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      D_stat   = 4'($urandom_range(0, 15));
      D_icode  = 4'($urandom_range(0, 15));
      D_ifun   = 4'($urandom_range(0, 15));
      D_rA     = 4'($urandom_range(0, 15));
      D_rB     = 4'($urandom_range(0, 15));
      D_valC   = {$urandom, $urandom};
      D_valP   = {$urandom, $urandom};
      e_dstE   = 4'($urandom_range(0, 15));
      M_dstE   = 4'($urandom_range(0, 15));
      M_dstM   = 4'($urandom_range(0, 15));
      W_dstE   = 4'($urandom_range(0, 15));
      W_dstM   = 4'($urandom_range(0, 15));
      e_valE   = {$urandom, $urandom};
      M_valE   = {$urandom, $urandom};
      m_valM   = {$urandom, $urandom};
      W_valE   = {$urandom, $urandom};
      W_valM   = {$urandom, $urandom};
      W_en     = 1'($urandom_range(0, 1));
      E_stall  = ($urandom_range(0, 7) == 0);
      E_bubble = ($urandom_range(0, 9) == 0);
      dbg_addr = 4'($urandom_range(0, 15));
      cycle();
    end
    E_stall = 1'b0; E_bubble = 1'b0;

    // Asynchronous reset mid-cycle, held across an edge with a pending write
    D_icode = 4'h6; D_rA = 4'd1; D_rB = 4'd2;
    cycle();
    clear_fwd();
    W_en = 1'b1; W_dstE = 4'd2; W_valE = 64'hDEAD; dbg_addr = 4'd2;
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_E_icode", 64'(E_icode), 64'h1);
    chk("arst_E_stat", 64'(E_stat), 64'h8);
    chk("arst_E_srcA", 64'(E_srcA), 64'hF);
    chk("arst_reg2", dbg_data, 64'h2);
    @(posedge clk); #1;
    chk("arst_blocked", dbg_data, 64'h2);
    chk("arst_blocked8", dbg_data8, 64'h2);
    @(negedge clk) rst_n = 1'b1;
    W_en = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_wb_param.md
Name: decode_wb_param

Overview:
- Parametrised Y86-64 decode/writeback stage with a 2-read/2-write register file.
- Provides operand forwarding from execute, memory and writeback, load-use hazard detection, and a stallable/bubblable E pipeline register.
- Sits between the fetch (D register) and execute stages. It replaces the fixed 64-bit, 15-register decode/writeback block.
- Adds reset, writeback enable, stall, hazard output and a debug read port.

Parameters:
- DATA_W, 64, datapath width of valC/valP/valA/valB/valE/valM and register entries.
- ADDR_W, 4, register-ID width. Required: 2**ADDR_W > NUM_REGS.
- NUM_REGS, 15, number of implemented registers, indexed 0..NUM_REGS-1.
- RSP_ID, 4, stack-pointer register ID used by call/ret/pushq/popq.
- INIT_INDEX, 1, reset value of reg i: 1 gives i, 0 gives 0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- D_stat  in  4  status of the instruction in decode.
- D_icode, D_ifun, D_rA, D_rB  in  4/4/ADDR_W/ADDR_W  decoded fields.
- D_valC, D_valP  in  DATA_W  constant and next PC.
- E_stall  in  1  hold the E register.
- E_bubble  in  1  load a bubble into the E register.
- e_dstE  in  ADDR_W  execute-stage destination; e_valE  in  DATA_W.
- M_dstE, M_dstM  in  ADDR_W; M_valE, m_valM  in  DATA_W.
- W_en  in  1  writeback enable (low for a bubble or a faulted status).
- W_dstE, W_dstM  in  ADDR_W; W_valE, W_valM  in  DATA_W.
- d_srcA, d_srcB  out  ADDR_W  combinational source IDs.
- load_use  out  1  combinational load-use hazard flag.
- E_stat, E_icode, E_ifun  out  4.
- E_valC, E_valA, E_valB  out  DATA_W.
- E_dstE, E_dstM, E_srcA, E_srcB  out  ADDR_W.
- dbg_addr  in  ADDR_W; dbg_data  out  DATA_W  combinational register-file read.

Behaviour:
- NONE is all-ones of width ADDR_W.
- Register IDs from NUM_REGS up to NONE-1 are out of range:
  - reads return 0;
  - writes are ignored.
- Source/destination decode defaults all four IDs (srcA, srcB, dstE, dstM) to NONE, then sets:
  - cmovXX(2): srcA=rA, dstE=rB.
  - irmovq(3): dstE=rB.
  - rmmovq(4): srcA=rA, srcB=rB.
  - mrmovq(5): srcB=rB, dstM=rA.
  - OPq(6): srcA=rA, srcB=rB, dstE=rB.
  - call(8): srcB=RSP, dstE=RSP.
  - ret(9): srcA=RSP, srcB=RSP, dstE=RSP.
  - pushq(A): srcA=rA, srcB=RSP, dstE=RSP.
  - popq(B): srcA=RSP, srcB=RSP, dstE=RSP, dstM=rA.
  - All other icodes keep NONE.
- Reads are combinational from the register file. They return the pre-edge contents; writeback values reach decode only through forwarding.
- valA selection, first match wins:
  1. D_icode is jXX(7) or call(8): D_valP.
  2. e_dstE: e_valE.
  3. M_dstM: m_valM.
  4. M_dstE: M_valE.
  5. W_dstM: W_valM.
  6. W_dstE: W_valE.
  7. Otherwise: register-file read.
  - A forwarding source matches only when its ID equals d_srcA and is not NONE.
- valB uses the same priority as valA, without step 1, matched against d_srcB.
- A src of NONE always yields 0.
- load_use = 1 when all of the following hold:
  - E_icode is mrmovq(5) or popq(B);
  - E_dstM is not NONE;
  - E_dstM equals d_srcA or d_srcB.
- The block does not act on load_use; the pipeline control unit drives E_bubble and the fetch/decode stalls.
- E register updates on the rising edge with priority rst_n low > E_bubble > E_stall > load:
  - Bubble/reset value: E_stat=4'b1000, E_icode=1 (nop), E_ifun=0, E_valC/E_valA/E_valB=0, all IDs NONE.
  - Stall: all E outputs hold.
  - Load: capture the D fields, d_valA/d_valB and the decoded IDs.
- Writeback happens on the rising edge when W_en=1:
  - W_valE is written to W_dstE, and W_valM to W_dstM, each only if its ID is in range.
  - If W_dstE equals W_dstM, W_valM wins (popq %rsp).
  - With W_en=0, nothing is written.
- Asynchronous reset (rst_n low) immediately:
  - forces the E register to the bubble value;
  - sets every register to its INIT_INDEX value;
  - blocks all writes while asserted, including mid-cycle.
- Decode and forwarding outputs remain combinational during reset.
- dbg_data is the current register-file content at dbg_addr, with 0 for out-of-range addresses.

Test Plan:
- Reset with INIT_INDEX=1, then sweep dbg_addr 0..14 -> dbg_data=i; E_icode=1; E_dstE=F; E_stat=8.
- D=OPq rA=2 rB=3, e_dstE=2 e_valE=0xAA, M_dstM=2 m_valM=0xBB -> E_valA=0xAA, E_valB=3 after the edge.
- W_en=1, W_dstE=4 W_valE=0x100, W_dstM=4 W_valM=0x200 -> reg4=0x200; repeat with W_en=0 -> reg4 unchanged.
- E holds mrmovq with dstM=5, D=OPq rA=5 -> load_use=1; D=OPq rA=6 rB=7 -> load_use=0.
- E_stall=1 with new D inputs -> E outputs unchanged; E_stall=1 and E_bubble=1 -> bubble loaded.
- NUM_REGS=8, ADDR_W=4: writeback to 9 ignored and read of 9 gives 0; D=jXX -> E_valA=D_valP; rst_n pulsed mid-cycle -> immediate bubble and register re-init.
